// File: rtl/touch_app_launcher.sv
// touch_app_launcher: home-screen launcher and app-lifecycle controller.
//   Maps FT6336 samples to rotated game coordinates, hit-tests the icon grid,
//   launches an app on tap, and returns home on a long corner hold or app_done.
// Ports:
//   clk_50, reset_n                 clock, async active-low reset
//   touch_valid/down/x/y            raw touch samples (panel axes)
//   app_done                        1-cycle request from the app to go home
//   in_home, active_app             framebuffer mux select, running app
//   app_start, app_exit             1-cycle lifecycle pulses
//   hover_valid, hover_idx          icon highlight while armed on home screen
//   game_x, game_y                  registered mapped coordinates
module touch_app_launcher #(
  parameter int GAME_W        = 320,
  parameter int GAME_H        = 240,
  parameter int NUM_APPS      = 6,
  parameter int IDX_W         = 3,
  parameter int COLS          = 3,
  parameter int ICON_W        = 48,
  parameter int ICON_H        = 48,
  parameter int GAP           = 16,
  parameter int GRID_X0       = 64,
  parameter int GRID_Y0       = 48,
  parameter int HIT_MARGIN    = 4,
  parameter int EXIT_SZ       = 32,
  parameter int EXIT_HOLD_CYC = 25_000_000
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             touch_valid,
  input  logic             touch_down,
  input  logic [11:0]      touch_x,
  input  logic [11:0]      touch_y,
  input  logic             app_done,
  output logic             in_home,
  output logic [IDX_W-1:0] active_app,
  output logic             app_start,
  output logic             app_exit,
  output logic             hover_valid,
  output logic [IDX_W-1:0] hover_idx,
  output logic [8:0]       game_x,
  output logic [8:0]       game_y
);

  localparam int NSLOT = 1 << IDX_W;
  localparam int CNT_W = (EXIT_HOLD_CYC > 1) ? $clog2(EXIT_HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXIT_HOLD_CYC - 1);

  typedef enum logic [1:0] {S_HOME, S_ARMED, S_APP} state_t;

  state_t           r_state;
  logic             r_in_home;
  logic [IDX_W-1:0] r_active_app;
  logic             r_app_start;
  logic             r_app_exit;
  logic             r_hover_valid;
  logic [IDX_W-1:0] r_hover_idx;
  logic [8:0]       r_game_x;
  logic [8:0]       r_game_y;
  logic             r_pressed;
  logic             r_press_pend;  // press_edge seen last cycle; coords now valid
  logic             r_down_pend;   // down sample seen last cycle; coords now valid
  logic [CNT_W-1:0] r_cnt;

  logic             w_press_edge;
  logic             w_release_edge;
  logic [8:0]       w_map_x;
  logic [8:0]       w_map_y;
  logic [NSLOT-1:0] w_hit;
  logic             w_any_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic             w_corner;
  logic             w_unused_bits;

  // Signed integer compare so a margin left of/above the screen edge cannot wrap.
  function automatic logic icon_hit(input int i, input int x, input int y);
    int x0;
    int y0;
    x0 = GRID_X0 + (i % COLS) * (ICON_W + GAP);
    y0 = GRID_Y0 + (i / COLS) * (ICON_H + GAP);
    return (i < NUM_APPS) &&
           (x >= x0 - HIT_MARGIN) && (x < x0 + ICON_W + HIT_MARGIN) &&
           (y >= y0 - HIT_MARGIN) && (y < y0 + ICON_H + HIT_MARGIN);
  endfunction

  assign w_unused_bits  = &{1'b0, touch_x[11:8], touch_y[11:9]};
  assign w_press_edge   = touch_valid && touch_down && !r_pressed;
  assign w_release_edge = touch_valid && !touch_down && r_pressed;

  // Panel is rotated: panel Y becomes game X, panel X becomes inverted game Y.
  assign w_map_x = (touch_y[8:0] > 9'(GAME_W - 1)) ? 9'(GAME_W - 1) : touch_y[8:0];
  assign w_map_y = (touch_x[7:0] > 8'(GAME_H - 1)) ? 9'd0
                                                   : 9'(GAME_H - 1) - {1'b0, touch_x[7:0]};

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NSLOT; i++) begin
      w_hit[i] = icon_hit(i, int'(r_game_x), int'(r_game_y));
    end
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = IDX_W'(i);
    end
  end

  assign w_any_hit = |w_hit;
  assign w_corner  = r_pressed && (r_game_x < 9'(EXIT_SZ)) && (r_game_y < 9'(EXIT_SZ));

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_HOME;
      r_in_home     <= 1'b1;
      r_active_app  <= '0;
      r_app_start   <= 1'b0;
      r_app_exit    <= 1'b0;
      r_hover_valid <= 1'b0;
      r_hover_idx   <= '0;
      r_game_x      <= '0;
      r_game_y      <= '0;
      r_pressed     <= 1'b0;
      r_press_pend  <= 1'b0;
      r_down_pend   <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_app_start  <= 1'b0;
      r_app_exit   <= 1'b0;
      r_press_pend <= w_press_edge;
      r_down_pend  <= touch_valid && touch_down;
      if (touch_valid) r_pressed <= touch_down;
      if (touch_valid && touch_down) begin
        r_game_x <= w_map_x;
        r_game_y <= w_map_y;
      end

      case (r_state)
        S_HOME: begin
          r_cnt <= '0;
          if (r_press_pend && w_any_hit) begin
            r_state       <= S_ARMED;
            r_hover_valid <= 1'b1;
            r_hover_idx   <= w_hit_idx;
          end
        end
        S_ARMED: begin
          // Sliding off the armed icon cancels; the later release launches nothing.
          if (r_down_pend && !w_hit[r_hover_idx]) begin
            r_state       <= S_HOME;
            r_hover_valid <= 1'b0;
          end else if (w_release_edge) begin
            r_state       <= S_APP;
            r_app_start   <= 1'b1;
            r_active_app  <= r_hover_idx;
            r_in_home     <= 1'b0;
            r_hover_valid <= 1'b0;
          end
        end
        S_APP: begin
          if (app_done || (w_corner && (r_cnt == CNT_LAST))) begin
            r_state    <= S_HOME;
            r_app_exit <= 1'b1;
            r_in_home  <= 1'b1;
            r_cnt      <= '0;
          end else if (w_corner) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
          end
        end
        default: r_state <= S_HOME;
      endcase
    end
  end

  assign in_home     = r_in_home;
  assign active_app  = r_active_app;
  assign app_start   = r_app_start;
  assign app_exit    = r_app_exit;
  assign hover_valid = r_hover_valid;
  assign hover_idx   = r_hover_idx;
  assign game_x      = r_game_x;
  assign game_y      = r_game_y;

endmodule

// File: tb/tb_touch_app_launcher.sv
module tb_touch_app_launcher;

  localparam int N_APPS = 5;
  localparam int HOLD   = 1000;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        touch_valid = 1'b0;
  logic        touch_down = 1'b0;
  logic [11:0] touch_x = '0;
  logic [11:0] touch_y = '0;
  logic        app_done = 1'b0;
  logic        in_home;
  logic [2:0]  active_app;
  logic        app_start;
  logic        app_exit;
  logic        hover_valid;
  logic [2:0]  hover_idx;
  logic [8:0]  game_x;
  logic [8:0]  game_y;

  always #10 clk_50 = ~clk_50;

  touch_app_launcher #(.NUM_APPS(N_APPS), .EXIT_HOLD_CYC(HOLD)) dut (
    .clk_50(clk_50), .reset_n(reset_n), .touch_valid(touch_valid), .touch_down(touch_down),
    .touch_x(touch_x), .touch_y(touch_y), .app_done(app_done), .in_home(in_home),
    .active_app(active_app), .app_start(app_start), .app_exit(app_exit),
    .hover_valid(hover_valid), .hover_idx(hover_idx), .game_x(game_x), .game_y(game_y)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_exit = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: screen mode plus the facts the rules depend on.
  localparam int HOME = 0, ARMED = 1, APP = 2;
  int m_mode, m_gx, m_gy, m_hidx, m_act, m_run;
  bit m_pressed, m_new_press, m_new_down, m_hv, m_start, m_exit;

  function automatic bit icon_hits(int i, int x, int y);
    int x0 = 64 + (i % 3) * 64;
    int y0 = 48 + (i / 3) * 64;
    return (i < N_APPS) && (x >= x0 - 4) && (x < x0 + 52) && (y >= y0 - 4) && (y < y0 + 52);
  endfunction

  function automatic int icon_at(int x, int y);
    for (int i = 0; i < N_APPS; i++) if (icon_hits(i, x, y)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = HOME; m_gx = 0; m_gy = 0; m_hidx = 0; m_act = 0; m_run = 0;
    m_pressed = 0; m_new_press = 0; m_new_down = 0; m_hv = 0; m_start = 0; m_exit = 0;
  endtask

  task automatic model_step();
    bit tv, td, in_corner;
    int tx, ty, under;
    tv = touch_valid; td = touch_down; tx = int'(touch_x); ty = int'(touch_y);
    m_start = 0; m_exit = 0;
    under = icon_at(m_gx, m_gy);
    in_corner = m_pressed && m_gx < 32 && m_gy < 32;
    if (m_mode == HOME) begin
      m_run = 0;
      if (m_new_press && under >= 0) begin m_mode = ARMED; m_hv = 1; m_hidx = under; end
    end else if (m_mode == ARMED) begin
      if (m_new_down && !icon_hits(m_hidx, m_gx, m_gy)) begin m_mode = HOME; m_hv = 0; end
      else if (tv && !td && m_pressed) begin
        m_mode = APP; m_start = 1; m_act = m_hidx; m_hv = 0;
      end
    end else begin
      m_run = in_corner ? m_run + 1 : 0;
      if (app_done || m_run == HOLD) begin m_mode = HOME; m_exit = 1; m_run = 0; end
    end
    m_new_press = tv && td && !m_pressed;
    m_new_down  = tv && td;
    if (tv && td) begin
      m_gx = (ty % 512 > 319) ? 319 : ty % 512;
      m_gy = 239 - ((tx % 256 > 239) ? 239 : tx % 256);
    end
    if (tv) m_pressed = td;
  endtask

  task automatic compare_all();
    check("in_home", in_home, (m_mode != APP));
    check("active_app", active_app, m_act);
    check("app_start", app_start, m_start);
    check("app_exit", app_exit, m_exit);
    check("hover_valid", hover_valid, m_hv);
    check("hover_idx", hover_idx, m_hidx);
    check("game_x", game_x, m_gx);
    check("game_y", game_y, m_gy);
    check("pulse_overlap", app_start && app_exit, 0);
  endtask

  task automatic cycle();
    @(posedge clk_50);
    if (reset_n) model_step(); else model_reset();
    #1;
    compare_all();
    if (app_start) n_start++;
    if (app_exit) n_exit++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic sample_raw(input bit d, input int tx, input int ty);
    touch_valid = 1'b1; touch_down = d; touch_x = 12'(tx); touch_y = 12'(ty);
    cycle();
    touch_valid = 1'b0;
  endtask

  task automatic touch_at(input bit d, input int gx, input int gy);
    sample_raw(d, 239 - gy, gx);
  endtask

  task automatic tap(input int gx, input int gy);
    touch_at(1, gx, gy); idle(2); touch_at(0, gx, gy); idle(2);
  endtask

  task automatic pulse_done();
    app_done = 1'b1; cycle(); app_done = 1'b0;
  endtask

  int s, e, n, holds;

  initial begin
    model_reset();
    idle(3);
    check("rst_in_home", in_home, 1);
    check("rst_game_x", game_x, 0);
    reset_n = 1'b1;
    idle(2);

    // T1: reset while armed
    touch_at(1, 152, 72); idle(2);
    check("t1_armed", hover_valid, 1);
    reset_n = 1'b0; #1; model_reset();
    check("t1_in_home", in_home, 1);
    check("t1_hover", hover_valid, 0);
    check("t1_active", active_app, 0);
    check("t1_pulses", {app_start, app_exit}, 0);
    idle(2); touch_at(0, 152, 72);
    reset_n = 1'b1; idle(2);

    // T2: tap icon 4
    s = n_start;
    tap(152, 136);
    check("t2_starts", n_start - s, 1);
    check("t2_active", active_app, 4);
    check("t2_in_home", in_home, 0);

    // T5: corner hold latency, then a 999-cycle hold that must not exit
    e = n_exit;
    touch_at(1, 8, 8);
    n = 0;
    while (!app_exit && n < 2000) begin cycle(); n++; end
    check("t5_exit_latency", n, HOLD);
    touch_at(0, 8, 8); idle(2);
    check("t5_home", in_home, 1);
    tap(152, 136);
    e = n_exit;
    touch_at(1, 8, 8); idle(HOLD - 2); touch_at(0, 8, 8); idle(20);
    check("t5_short_hold", n_exit - e, 0);
    check("t5_still_app", in_home, 0);

    // T6: app_done on the expiry cycle gives one pulse; clamp mapping
    e = n_exit;
    touch_at(1, 8, 8); idle(HOLD - 1); pulse_done();
    touch_at(0, 8, 8); idle(5);
    check("t6_single_exit", n_exit - e, 1);
    sample_raw(1, 250, 400); idle(1);
    check("t6_clamp_x", game_x, 319);
    check("t6_clamp_y", game_y, 0);
    sample_raw(0, 0, 0); idle(2);

    // T3: press then slide off cancels
    s = n_start;
    touch_at(1, 88, 72); idle(2);
    check("t3_hover_on", hover_valid, 1);
    touch_at(1, 200, 20); idle(2);
    check("t3_hover_off", hover_valid, 0);
    touch_at(0, 200, 20); idle(3);
    check("t3_no_start", n_start - s, 0);
    check("t3_home", in_home, 1);

    // T4: margin hit, gap miss, missing icon 5
    s = n_start;
    tap(60, 72);
    check("t4_margin_start", n_start - s, 1);
    check("t4_active", active_app, 0);
    pulse_done(); idle(2);
    s = n_start;
    tap(116, 72);
    tap(216, 136);
    check("t4_no_start", n_start - s, 0);
    check("t4_home", in_home, 1);

    // Randomized operation mix, checked every cycle against the model
    holds = 0;
    for (int it = 0; it < 250; it++) begin
      int op, i, gx, gy;
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          i  = $urandom_range(0, 5);
          gx = 64 + (i % 3) * 64 + 24 + $urandom_range(0, 60) - 30;
          gy = 48 + (i / 3) * 64 + 24 + $urandom_range(0, 60) - 30;
          touch_at(1, gx, gy); idle($urandom_range(0, 4));
          touch_at(0, gx, gy); idle($urandom_range(0, 4));
        end
        1: tap($urandom_range(0, 319), $urandom_range(0, 239));
        2: begin
          i = $urandom_range(0, 5);
          touch_at(1, 88 + (i % 3) * 64, 72 + (i / 3) * 64); idle($urandom_range(0, 3));
          touch_at(1, $urandom_range(0, 319), $urandom_range(0, 239)); idle($urandom_range(0, 3));
          touch_at(0, 0, 0); idle(2);
        end
        3: begin pulse_done(); idle($urandom_range(0, 3)); end
        4: begin
          touch_at(1, $urandom_range(0, 31), $urandom_range(0, 31));
          if (holds < 20) begin holds++; idle($urandom_range(HOLD - 10, HOLD + 5)); end
          else idle(50);
          touch_at(0, 0, 0); idle(2);
        end
        default: begin
          sample_raw($urandom_range(0, 1), $urandom_range(0, 4095), $urandom_range(0, 4095));
          idle($urandom_range(0, 2));
        end
      endcase
    end
    touch_at(0, 0, 0); idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
